// File: rtl/uart_rx_param_if.sv
// uart_rx_param_if: serial input and received-frame outputs of the UART receiver.
// master = the receiver, slave = the line driver / byte consumer side.
interface uart_rx_param_if #(
   parameter int DATA_BITS = 8
);
   logic                 i_Rx_Serial;
   logic                 o_Rx_DV;
   logic [DATA_BITS-1:0] o_Rx_Data;
   logic                 o_Parity_Err;
   logic                 o_Frame_Err;
   logic                 o_Busy;

   modport master (
      input  i_Rx_Serial,
      output o_Rx_DV, o_Rx_Data, o_Parity_Err, o_Frame_Err, o_Busy
   );

   modport slave (
      output i_Rx_Serial,
      input  o_Rx_DV, o_Rx_Data, o_Parity_Err, o_Frame_Err, o_Busy
   );
endinterface

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with a 2-flop input synchroniser,
// start-bit glitch rejection and parity / framing error flags.
// Optional macro UART_RX_MAJORITY_EN: every bit decision becomes a 2-of-3 vote
// over the last three synchronised samples instead of a single sample.
//
// state  | meaning
// IDLE   | waiting for a falling edge, only after the line has been seen high
// START  | timing to the middle of the start bit to confirm it is real
// DATA   | sampling data bits LSB first, one per bit period
// PARITY | sampling the parity bit
// STOP   | sampling stop bit(s); the frame is delivered at the last one
module uart_rx_param #(
   parameter int CLKS_PER_BIT = 87,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_MODE  = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic            i_Clock,
   input  logic            i_Reset,
   uart_rx_param_if.master rx_if
);
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] HALF      = CNT_W'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CNT_W-1:0] LAST      = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
   localparam logic             LAST_STOP = (STOP_BITS == 2);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic                 stop_idx_q, stop_idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 perr_q, perr_d;
   logic                 ferr_q, ferr_d;
   logic                 seen_q, seen_d;
   logic                 dv_q, dv_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 perr_out_q, perr_out_d;
   logic                 ferr_out_q, ferr_out_d;
   logic                 sync1_q, sync2_q;
   logic                 rx_s, rx_v;

   // two-flop synchroniser; resets to the idle (high) line level
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= rx_if.i_Rx_Serial;
         sync2_q <= sync1_q;
      end
   end

   assign rx_s = sync2_q;

`ifdef UART_RX_MAJORITY_EN
   logic hist1_q, hist2_q;

   // two previous synchronised samples feeding the 2-of-3 vote
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         hist1_q <= 1'b1;
         hist2_q <= 1'b1;
      end else begin
         hist1_q <= rx_s;
         hist2_q <= hist1_q;
      end
   end

   assign rx_v = (rx_s & hist1_q) | (rx_s & hist2_q) | (hist1_q & hist2_q);
`else
   assign rx_v = rx_s;
`endif

   // next-state and output decode for the frame FSM
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      stop_idx_d = stop_idx_q;
      shift_d    = shift_q;
      perr_d     = perr_q;
      ferr_d     = ferr_q;
      seen_d     = seen_q;
      data_d     = data_q;
      dv_d       = 1'b0;
      perr_out_d = 1'b0;
      ferr_out_d = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (rx_s) begin
               seen_d = 1'b1;
            end else if (seen_q) begin
               // seen_q blocks re-arming while a break keeps the line low
               state_d = START;
               perr_d  = 1'b0;
               ferr_d  = 1'b0;
               seen_d  = 1'b0;
            end
         end
         START: begin
            if (cnt_q == HALF) begin
               cnt_d = '0;
               idx_d = '0;
               state_d = rx_v ? IDLE : DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DATA: begin
            if (cnt_q == LAST) begin
               cnt_d          = '0;
               shift_d[idx_q] = rx_v;
               if (idx_q == LAST_IDX) begin
                  stop_idx_d = 1'b0;
                  state_d    = (PARITY_MODE != 0) ? PARITY : STOP;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PARITY: begin
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               perr_d  = (PARITY_MODE == 1) ? ~(^shift_q ^ rx_v) : (^shift_q ^ rx_v);
               state_d = STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         STOP: begin
            if (cnt_q == LAST) begin
               cnt_d = '0;
               if (!rx_v) ferr_d = 1'b1;
               if (stop_idx_q == LAST_STOP) begin
                  // deliver mid stop bit so a back-to-back start edge is not missed
                  dv_d       = 1'b1;
                  data_d     = shift_q;
                  perr_out_d = perr_q;
                  ferr_out_d = ferr_q | ~rx_v;
                  state_d    = IDLE;
               end else begin
                  stop_idx_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // frame FSM state and registered outputs
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         stop_idx_q <= 1'b0;
         shift_q    <= '0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         seen_q     <= 1'b0;
         dv_q       <= 1'b0;
         data_q     <= '0;
         perr_out_q <= 1'b0;
         ferr_out_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         stop_idx_q <= stop_idx_d;
         shift_q    <= shift_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         seen_q     <= seen_d;
         dv_q       <= dv_d;
         data_q     <= data_d;
         perr_out_q <= perr_out_d;
         ferr_out_q <= ferr_out_d;
      end
   end

   assign rx_if.o_Rx_DV      = dv_q;
   assign rx_if.o_Rx_Data    = data_q;
   assign rx_if.o_Parity_Err = (PARITY_MODE != 0) ? perr_out_q : 1'b0;
   assign rx_if.o_Frame_Err  = ferr_out_q;
   assign rx_if.o_Busy       = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: five receiver configurations on independent serial lines,
// directed vector table, multi-cycle corner sequences and random frames
// checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_rx_param;
   localparam int NL = 5;

   typedef struct {
      int         ln;
      logic [8:0] d;
      logic       pe;
      logic       fe;
   } rec_t;

   typedef struct {
      int         ln;
      logic [8:0] d;
      logic       pflip;
      logic       s0;
      logic       s1;
      bit         glitch;
      logic [8:0] ed;
      logic       epe;
      logic       efe;
   } vec_t;

   logic clk;
   logic rst;
   logic       ser [NL];
   logic       dv  [NL];
   logic [8:0] dat [NL];
   logic       pe  [NL];
   logic       fe  [NL];
   logic       bz  [NL];
   logic       dv_prev [NL];

   int   nchk = 0;
   int   nerr = 0;
   rec_t rxq[$];

   initial clk = 1'b0;
   always #50 clk = ~clk;

   uart_rx_param_if #(.DATA_BITS(8)) if0 ();
   uart_rx_param_if #(.DATA_BITS(7)) if1 ();
   uart_rx_param_if #(.DATA_BITS(8)) if2 ();
   uart_rx_param_if #(.DATA_BITS(9)) if3 ();
   uart_rx_param_if #(.DATA_BITS(5)) if4 ();

   uart_rx_param #(.CLKS_PER_BIT(87), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1))
      u0 (.i_Clock(clk), .i_Reset(rst), .rx_if(if0));
   uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(1))
      u1 (.i_Clock(clk), .i_Reset(rst), .rx_if(if1));
   uart_rx_param #(.CLKS_PER_BIT(12), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2))
      u2 (.i_Clock(clk), .i_Reset(rst), .rx_if(if2));
   uart_rx_param #(.CLKS_PER_BIT(9),  .DATA_BITS(9), .PARITY_MODE(1), .STOP_BITS(2))
      u3 (.i_Clock(clk), .i_Reset(rst), .rx_if(if3));
   uart_rx_param #(.CLKS_PER_BIT(4),  .DATA_BITS(5), .PARITY_MODE(1), .STOP_BITS(1))
      u4 (.i_Clock(clk), .i_Reset(rst), .rx_if(if4));

   assign if0.i_Rx_Serial = ser[0];
   assign if1.i_Rx_Serial = ser[1];
   assign if2.i_Rx_Serial = ser[2];
   assign if3.i_Rx_Serial = ser[3];
   assign if4.i_Rx_Serial = ser[4];

   assign dv[0] = if0.o_Rx_DV;  assign dat[0] = 9'(if0.o_Rx_Data);
   assign dv[1] = if1.o_Rx_DV;  assign dat[1] = 9'(if1.o_Rx_Data);
   assign dv[2] = if2.o_Rx_DV;  assign dat[2] = 9'(if2.o_Rx_Data);
   assign dv[3] = if3.o_Rx_DV;  assign dat[3] = 9'(if3.o_Rx_Data);
   assign dv[4] = if4.o_Rx_DV;  assign dat[4] = if4.o_Rx_Data;
   assign pe[0] = if0.o_Parity_Err; assign fe[0] = if0.o_Frame_Err; assign bz[0] = if0.o_Busy;
   assign pe[1] = if1.o_Parity_Err; assign fe[1] = if1.o_Frame_Err; assign bz[1] = if1.o_Busy;
   assign pe[2] = if2.o_Parity_Err; assign fe[2] = if2.o_Frame_Err; assign bz[2] = if2.o_Busy;
   assign pe[3] = if3.o_Parity_Err; assign fe[3] = if3.o_Frame_Err; assign bz[3] = if3.o_Busy;
   assign pe[4] = if4.o_Parity_Err; assign fe[4] = if4.o_Frame_Err; assign bz[4] = if4.o_Busy;

   function automatic int cpb_of(input int ln);
      case (ln)
         0: return 87;
         1: return 16;
         2: return 12;
         3: return 9;
         default: return 4;
      endcase
   endfunction

   function automatic int nb_of(input int ln);
      case (ln)
         0: return 8;
         1: return 7;
         2: return 8;
         3: return 9;
         default: return 5;
      endcase
   endfunction

   function automatic int pm_of(input int ln);
      case (ln)
         1: return 2;
         3: return 1;
         4: return 1;
         default: return 0;
      endcase
   endfunction

   function automatic int ns_of(input int ln);
      return (ln == 2 || ln == 3) ? 2 : 1;
   endfunction

   function automatic logic [8:0] mask_of(input int ln);
      return 9'((1 << nb_of(ln)) - 1);
   endfunction

   // parity bit a correct transmitter would send, optionally inverted
   function automatic logic tx_parity(input int ln, input logic [8:0] d, input logic flip);
      logic [8:0] dm;
      dm = d & mask_of(ln);
      return ((pm_of(ln) == 1) ? ~(^dm) : (^dm)) ^ flip;
   endfunction

   // reference model: what the receiver must report for a given transmitted frame
   function automatic rec_t model(input int ln, input logic [8:0] d, input logic pflip,
                                  input logic s0, input logic s1);
      rec_t r;
      logic x;
      r.ln = ln;
      r.d  = d & mask_of(ln);
      x    = (^r.d) ^ tx_parity(ln, d, pflip);
      if (pm_of(ln) == 0)      r.pe = 1'b0;
      else if (pm_of(ln) == 1) r.pe = (x == 1'b0);
      else                     r.pe = (x == 1'b1);
      r.fe = !s0 || (ns_of(ln) == 2 && !s1);
      return r;
   endfunction

   // frame monitor plus single-cycle pulse check on DV and the flags
   always @(negedge clk) begin
      rec_t r;
      for (int i = 0; i < NL; i++) begin
         if (dv[i] === 1'b1) begin
            r.ln = i; r.d = dat[i]; r.pe = pe[i]; r.fe = fe[i];
            rxq.push_back(r);
         end
         if (dv_prev[i] === 1'b1) begin
            nchk++;
            if (dv[i] !== 1'b0 || pe[i] !== 1'b0 || fe[i] !== 1'b0) begin
               nerr++;
               $display("FAIL pulse_drop line %0d: dv=%b pe=%b fe=%b, want all 0", i, dv[i], pe[i], fe[i]);
            end
         end
         dv_prev[i] <= dv[i];
      end
   end

   task automatic chk(input string nm, input logic [8:0] got, input logic [8:0] want);
      nchk++;
      if (got !== want) begin
         nerr++;
         $display("FAIL %s: got %h want %h", nm, got, want);
      end
   endtask

   task automatic drive_bit(input int ln, input logic v, input int n);
      for (int k = 0; k < n; k++) begin
         ser[ln] = v;
         @(negedge clk);
      end
   endtask

   task automatic send_frame(input int ln, input logic [8:0] d, input logic pflip,
                             input logic s0, input logic s1, input bit glitch);
      int cpb;
      int half;
      cpb  = cpb_of(ln);
      half = (cpb - 1) / 2;
      drive_bit(ln, 1'b0, cpb);
      for (int b = 0; b < nb_of(ln); b++) begin
         if (glitch) begin
            drive_bit(ln, d[b], half + 1);
            drive_bit(ln, ~d[b], 1);
            drive_bit(ln, d[b], cpb - half - 2);
         end else begin
            drive_bit(ln, d[b], cpb);
         end
      end
      if (pm_of(ln) != 0) drive_bit(ln, tx_parity(ln, d, pflip), cpb);
      drive_bit(ln, s0, cpb);
      if (ns_of(ln) == 2) drive_bit(ln, s1, cpb);
   endtask

   task automatic check_rec(input string nm, input rec_t r, input rec_t e);
      chk({nm, "_line"}, 9'(r.ln), 9'(e.ln));
      chk({nm, "_data"}, r.d, e.d);
      chk({nm, "_perr"}, {8'd0, r.pe}, {8'd0, e.pe});
      chk({nm, "_ferr"}, {8'd0, r.fe}, {8'd0, e.fe});
   endtask

   task automatic check_one(input string nm, input int ln, input rec_t e, input int gap);
      rec_t r;
      drive_bit(ln, 1'b1, gap);
      #1;
      chk({nm, "_count"}, 9'(rxq.size()), 9'd1);
      if (rxq.size() > 0) begin
         r = rxq.pop_front();
         check_rec(nm, r, e);
      end
      chk({nm, "_hold"}, dat[ln], e.d);
      chk({nm, "_busy"}, {8'd0, bz[ln]}, 9'd0);
      rxq.delete();
   endtask

   initial begin
      #10_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t tbl [8];
      rec_t e;
      rec_t r;
      logic [8:0] rd;
      logic rpf, rs0, rs1;
      int nfr;
      bit busy_seen;

      tbl[0] = '{0, 9'h03B, 1'b0, 1'b1, 1'b1, 1'b0, 9'h03B, 1'b0, 1'b0};
      tbl[1] = '{1, 9'h055, 1'b0, 1'b1, 1'b1, 1'b0, 9'h055, 1'b0, 1'b0};
      tbl[2] = '{1, 9'h055, 1'b1, 1'b1, 1'b1, 1'b0, 9'h055, 1'b1, 1'b0};
      tbl[3] = '{2, 9'h0A5, 1'b0, 1'b1, 1'b0, 1'b0, 9'h0A5, 1'b0, 1'b1};
      tbl[4] = '{2, 9'h012, 1'b0, 1'b1, 1'b1, 1'b0, 9'h012, 1'b0, 1'b0};
`ifdef UART_RX_MAJORITY_EN
      tbl[5] = '{0, 9'h0C3, 1'b0, 1'b1, 1'b1, 1'b1, 9'h0C3, 1'b0, 1'b0};
`else
      tbl[5] = '{0, 9'h0C3, 1'b0, 1'b1, 1'b1, 1'b1, 9'h03C, 1'b0, 1'b0};
`endif
      tbl[6] = '{3, 9'h1A5, 1'b0, 1'b0, 1'b1, 1'b0, 9'h1A5, 1'b0, 1'b1};
      tbl[7] = '{4, 9'h015, 1'b1, 1'b1, 1'b1, 1'b0, 9'h015, 1'b1, 1'b0};

      for (int i = 0; i < NL; i++) begin
         ser[i] = 1'b1;
         dv_prev[i] = 1'b0;
      end
      rst = 1'b0;
      #10;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      for (int i = 0; i < NL; i++)
         chk($sformatf("reset_line%0d", i),
             {4'd0, dv[i], pe[i], fe[i], bz[i], |dat[i]}, 9'd0);
      rst = 1'b0;
      drive_bit(0, 1'b1, 4);
      rxq.delete();

      // directed vector table
      for (int i = 0; i < 8; i++) begin
         send_frame(tbl[i].ln, tbl[i].d, tbl[i].pflip, tbl[i].s0, tbl[i].s1, tbl[i].glitch);
         e.ln = tbl[i].ln; e.d = tbl[i].ed; e.pe = tbl[i].epe; e.fe = tbl[i].efe;
         check_one($sformatf("vec%0d", i), tbl[i].ln, e, 4);
      end

      // back-to-back frames with no idle time between them
      send_frame(0, 9'h0A7, 1'b0, 1'b1, 1'b1, 1'b0);
      send_frame(0, 9'h05C, 1'b0, 1'b1, 1'b1, 1'b0);
      drive_bit(0, 1'b1, 4);
      #1;
      chk("b2b_count", 9'(rxq.size()), 9'd2);
      if (rxq.size() == 2) begin
         e = '{0, 9'h0A7, 1'b0, 1'b0};
         r = rxq.pop_front();
         check_rec("b2b_first", r, e);
         e = '{0, 9'h05C, 1'b0, 1'b0};
         r = rxq.pop_front();
         check_rec("b2b_second", r, e);
      end
      rxq.delete();

      // 20-clock low pulse on an idle line is rejected as a glitch
      busy_seen = 1'b0;
      for (int k = 0; k < 43 + 4; k++) begin
         ser[0] = (k < 20) ? 1'b0 : 1'b1;
         @(negedge clk);
         if (bz[0] === 1'b1) busy_seen = 1'b1;
      end
      chk("glitch_busy_seen", {8'd0, busy_seen}, 9'd1);
      chk("glitch_busy_end", {8'd0, bz[0]}, 9'd0);
      drive_bit(0, 1'b1, 87);
      chk("glitch_no_dv", 9'(rxq.size()), 9'd0);
      rxq.delete();

      // break: line low for more than a frame, then recovery
      drive_bit(0, 1'b0, 12 * 87);
      #1;
      chk("break_count", 9'(rxq.size()), 9'd1);
      if (rxq.size() > 0) begin
         e = '{0, 9'h000, 1'b0, 1'b1};
         r = rxq.pop_front();
         check_rec("break", r, e);
      end
      chk("break_idle", {8'd0, bz[0]}, 9'd0);
      rxq.delete();
      drive_bit(0, 1'b1, 87);
      chk("break_no_rearm", 9'(rxq.size()), 9'd0);
      send_frame(0, 9'h05A, 1'b0, 1'b1, 1'b1, 1'b0);
      e = '{0, 9'h05A, 1'b0, 1'b0};
      check_one("after_break", 0, e, 4);

      // reset in data bit 4 of 0xFF abandons the frame
      drive_bit(0, 1'b0, 87);
      drive_bit(0, 1'b1, 4 * 87 + 43);
      chk("rst_busy_before", {8'd0, bz[0]}, 9'd1);
      rst = 1'b1;
      drive_bit(0, 1'b1, 1);
      chk("rst_busy_during", {7'd0, bz[0], dv[0]}, 9'd0);
      drive_bit(0, 1'b1, 2);
      rst = 1'b0;
      drive_bit(0, 1'b1, 87 - 43 - 3 + 3 * 87 + 2 * 87);
      #1;
      chk("rst_no_dv", 9'(rxq.size()), 9'd0);
      chk("rst_data_clear", dat[0], 9'h000);
      rxq.delete();
      send_frame(0, 9'h081, 1'b0, 1'b1, 1'b1, 1'b0);
      e = '{0, 9'h081, 1'b0, 1'b0};
      check_one("after_rst", 0, e, 4);

      // random frames on every configuration against the reference model
      for (int ln = 0; ln < NL; ln++) begin
         nfr = (ln == 0) ? 5 : 25;
         for (int f = 0; f < nfr; f++) begin
            rd  = 9'($urandom);
            rpf = (pm_of(ln) != 0) && ($urandom_range(0, 3) == 0);
            rs0 = ($urandom_range(0, 4) != 0);
            rs1 = ($urandom_range(0, 4) != 0);
            send_frame(ln, rd, rpf, rs0, rs1, 1'b0);
            e = model(ln, rd, rpf, rs0, rs1);
            check_one($sformatf("rand_l%0d_f%0d", ln, f), ln, e, 4 + int'($urandom_range(0, 3)));
         end
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised next-generation UART receiver with configurable clocks-per-bit, data width, parity and stop-bit count. Adds input synchronisation, start-bit glitch rejection, parity-error and framing-error flags to the existing fixed 8N1 receiver. Sits between the serial pin and the command/byte-handling logic. Sets o_Rx_DV for one clock per received frame.

Parameters:
CLKS_PER_BIT, 87, system clocks per bit; legal range is 4 or more.
DATA_BITS, 8, data bits per frame, 5..9, sent LSB first.
PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, 1 or 2.

Ports:
i_Clock  in  1  system clock; all logic is on the rising edge.
i_Reset  in  1  asynchronous, active-high reset.
i_Rx_Serial  in  1  serial line; idles high; asynchronous to i_Clock.
o_Rx_DV  out  1  one-cycle pulse when a frame completes.
o_Rx_Data  out  DATA_BITS  received word; holds its value until the next o_Rx_DV.
o_Parity_Err  out  1  high during the o_Rx_DV cycle if the parity check failed.
o_Frame_Err  out  1  high during the o_Rx_DV cycle if any stop bit was sampled as 0.
o_Busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset values: all outputs 0 and state IDLE. The synchroniser flops and the majority history reset to 1.
- Synchroniser: i_Rx_Serial passes through 2 flops to give rx_s. All decisions use the value rx_s (or rx_v, defined below). This adds a fixed 2-clock latency.
- Bit counter: cnt counts 0..CLKS_PER_BIT-1. Half-point: HALF = (CLKS_PER_BIT-1)/2.
- rx_v:
  - Without the optional feature: rx_v = rx_s.
  - With the optional feature: rx_v is the majority vote (see Optional Feature).
- IDLE:
  - cnt = 0.
  - When rx_s = 0: go to START.
- START:
  - Increment cnt.
  - At cnt == HALF:
    - If rx_v = 0: go to DATA with cnt = 0 and bit index = 0.
    - Otherwise: glitch; return to IDLE. No DV and no error flag.
- DATA:
  - At cnt == CLKS_PER_BIT-1: shift rx_v into shift[index] and reset cnt to 0.
  - After DATA_BITS samples: go to PARITY if PARITY_MODE != 0, otherwise go to STOP.
- PARITY:
  - At cnt == CLKS_PER_BIT-1: sample the parity bit, then go to STOP.
  - perr = 1 if (XOR of data bits) XOR (parity bit) equals 0 for odd mode, or equals 1 for even mode.
- STOP:
  - Sample at cnt == CLKS_PER_BIT-1, once per stop bit.
  - Any sample of 0 sets ferr.
  - After the last stop sample, in the same cycle:
    - o_Rx_DV = 1.
    - o_Rx_Data = shift.
    - o_Parity_Err = perr and o_Frame_Err = ferr; both are valid only while DV is high.
    - Go to IDLE.
- Output timing:
  - o_Rx_DV and both error flags drop to 0 on the next clock.
  - perr and ferr clear on entry to START.
- Back-to-back frames: IDLE is re-entered at the middle of the stop bit, so a start edge in the following bit period is detected. There is no dead time beyond the 2-clock synchroniser.
- Break (line held at 0 for a whole frame): completes as a normal frame with o_Frame_Err = 1. The receiver then re-arms only after rx_s returns to 1 and then falls again. A per-frame "seen high" latch is set in IDLE.
- Reset mid-frame: the frame is abandoned immediately. No DV is produced for it.
- PARITY_MODE = 0: o_Parity_Err is tied to 0.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- When defined:
  - A 3-deep history of rx_s is kept.
  - Every sampling decision (start check, data, parity and stop) uses the 2-of-3 majority of rx_s at cnt-2, cnt-1 and cnt.
  - CLKS_PER_BIT must be 4 or more.
- When undefined:
  - Single-sample decision on rx_s at the decision cycle.
  - No history registers are built.

Test Plan:
- Default 8N1, CLKS_PER_BIT = 87, 100 ns clock, send 0x3B with an 8700 ns bit period -> exactly one o_Rx_DV pulse, o_Rx_Data = 0x3B, both error flags 0, o_Busy back to 0.
- PARITY_MODE = 2, DATA_BITS = 7, send 0x55 with a correct parity bit, then 0x55 with the parity bit inverted -> DV with perr = 0, then DV with perr = 1; data = 0x55 both times.
- STOP_BITS = 2, send 0xA5 with the second stop bit forced to 0 -> DV with o_Frame_Err = 1 and data = 0xA5. The next good frame, 0x12, gives ferr = 0.
- 20-clock low pulse on an idle line -> no DV. o_Busy goes high and then returns to 0 by HALF+3 clocks after the edge.
- Assert i_Reset for 3 clocks during data bit 4 of 0xFF, then send 0x81 -> no DV for the aborted frame; one DV with 0x81.
- With UART_RX_MAJORITY_EN defined, send 0xC3 with a 1-clock inverted glitch at the centre of every data bit -> data = 0xC3, no errors. Without the macro, the same stimulus gives 0x3C (every bit flipped).
